// File: rtl/foc_pkg.sv
// -----------------------------------------------------------------------------
// foc_pkg
// Shared types and defaults for the FOC control-loop blocks.
//   pi_ch_e          : PI job channel code sent to the shared PI core
//   pi_sched_state_e : pi_scheduler sequencing states
//   PI_N_DEF/PI_F_DEF: default data width and extra integrator bits
//   state_ch()       : channel that a scheduler state works on
// -----------------------------------------------------------------------------
package foc_pkg;

  localparam int PI_N_DEF = 10;
  localparam int PI_F_DEF = 9;

  typedef enum logic [1:0] {
    CH_D   = 2'd0,
    CH_Q   = 2'd1,
    CH_SPD = 2'd2
  } pi_ch_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPD_ISSUE = 3'd1,
    ST_SPD_WAIT  = 3'd2,
    ST_D_ISSUE   = 3'd3,
    ST_D_WAIT    = 3'd4,
    ST_Q_ISSUE   = 3'd5,
    ST_Q_WAIT    = 3'd6,
    ST_COMMIT    = 3'd7
  } pi_sched_state_e;

  // IDLE and COMMIT report the d channel so that pi_ch rests at 0.
  function automatic pi_ch_e state_ch(input pi_sched_state_e s);
    case (s)
      ST_SPD_ISSUE, ST_SPD_WAIT: return CH_SPD;
      ST_Q_ISSUE, ST_Q_WAIT:     return CH_Q;
      default:                   return CH_D;
    endcase
  endfunction

endpackage

// File: rtl/pi_scheduler_integ_bank.sv
// -----------------------------------------------------------------------------
// pi_integ_bank
// Three-entry register file holding the private PI integrator of each channel.
//   clk, nrst : clock, synchronous active-low reset
//   clr       : synchronous clear of all entries (loop disabled)
//   rd_ch     : read index (channel of the job being issued / awaited)
//   rd_data   : integrator of rd_ch, combinational so it is valid in the
//               same cycle as pi_start
//   wr_en     : write strobe (accepted pi_done)
//   wr_ch     : write index
//   wr_data   : updated integrator from the core
// -----------------------------------------------------------------------------
module pi_integ_bank
  import foc_pkg::*;
#(
  parameter int W = PI_N_DEF + PI_F_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic [1:0]   rd_ch,
  output logic [W-1:0] rd_data,
  input  logic         wr_en,
  input  logic [1:0]   wr_ch,
  input  logic [W-1:0] wr_data
);

  logic [W-1:0] entry_q [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_entry
      logic [W-1:0] integ_reg;

      always_ff @(posedge clk) begin
        if (!nrst || clr) begin
          integ_reg <= '0;
        end else if (wr_en && (wr_ch == 2'(gi))) begin
          integ_reg <= wr_data;
        end
      end

      assign entry_q[gi] = integ_reg;
    end
  endgenerate

  // Code 3 is not a channel; read it as zero rather than index out of range.
  always_comb begin
    rd_data = '0;
    case (rd_ch)
      2'd0:    rd_data = entry_q[0];
      2'd1:    rd_data = entry_q[1];
      2'd2:    rd_data = entry_q[2];
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/pi_scheduler.sv
// -----------------------------------------------------------------------------
// pi_scheduler
// Time-shares one external PI core between the speed, d-current and q-current
// loops. Each trig starts a control cycle: optional speed job (every SPD_DIV
// triggers when spd_mode=1), then the d job, then the q job, then a commit
// that updates vd/vq together.
//   clk, nrst          : clock, synchronous active-low reset
//   en                 : loop enable; low aborts and clears all loop state
//   trig               : PWM sync pulse
//   spd_mode           : q reference from speed PI (1) or iq_ref_ext (0)
//   spd_ref/spd_fb, id_ref/id_fb, iq_ref_ext/iq_fb : signed loop operands
//   clr_err            : clears overrun / timeout_err
//   pi_start, pi_ch, pi_ref, pi_fb, pi_integ_in     : job request to the core
//   pi_done, pi_out, pi_integ_out                   : core response
//   vd, vq, v_valid    : committed voltage commands and update strobe
//   busy               : sequencer not idle
//   overrun            : sticky, trig seen while busy
//   timeout_err        : sticky, core silent for TIMEOUT cycles
// -----------------------------------------------------------------------------
module pi_scheduler
  import foc_pkg::*;
#(
  parameter int N       = PI_N_DEF,
  parameter int F       = PI_F_DEF,
  parameter int SPD_DIV = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                trig,
  input  logic                spd_mode,
  input  logic signed [N-1:0] spd_ref,
  input  logic signed [N-1:0] spd_fb,
  input  logic signed [N-1:0] id_ref,
  input  logic signed [N-1:0] iq_ref_ext,
  input  logic signed [N-1:0] id_fb,
  input  logic signed [N-1:0] iq_fb,
  input  logic                clr_err,
  output logic                pi_start,
  output logic [1:0]          pi_ch,
  output logic signed [N-1:0] pi_ref,
  output logic signed [N-1:0] pi_fb,
  output logic [N+F-1:0]      pi_integ_in,
  input  logic                pi_done,
  input  logic signed [N-1:0] pi_out,
  input  logic [N+F-1:0]      pi_integ_out,
  output logic signed [N-1:0] vd,
  output logic signed [N-1:0] vq,
  output logic                v_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int DW = (SPD_DIV > 1) ? $clog2(SPD_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SPD_DIV - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  pi_sched_state_e     state_reg, state_next;
  pi_ch_e              ch;
  logic [DW-1:0]       div_cnt_reg;
  logic [TW-1:0]       wait_cnt_reg;
  logic signed [N-1:0] ref_hold_reg, fb_hold_reg;
  logic signed [N-1:0] iq_sp_reg, vd_shadow_reg, vq_shadow_reg;
  logic signed [N-1:0] vd_reg, vq_reg;
  logic                v_valid_reg, overrun_reg, timeout_reg;
  logic signed [N-1:0] live_ref, live_fb;
  logic                in_issue, in_wait, job_done, wait_expired;
  logic                trig_accept;

  assign ch       = state_ch(state_reg);
  assign in_issue = (state_reg == ST_SPD_ISSUE) || (state_reg == ST_D_ISSUE) ||
                    (state_reg == ST_Q_ISSUE);
  assign in_wait  = (state_reg == ST_SPD_WAIT) || (state_reg == ST_D_WAIT) ||
                    (state_reg == ST_Q_WAIT);
  assign job_done = in_wait && pi_done;
  // pi_done in the last allowed cycle still counts as an answer.
  assign wait_expired = in_wait && !pi_done && (wait_cnt_reg == WAIT_LAST);
  assign trig_accept  = trig && (state_reg == ST_IDLE);

  // Operand selection for the job being issued this cycle.
  always_comb begin
    live_ref = '0;
    live_fb  = '0;
    case (ch)
      CH_SPD: begin
        live_ref = spd_ref;
        live_fb  = spd_fb;
      end
      CH_Q: begin
        live_ref = spd_mode ? iq_sp_reg : iq_ref_ext;
        live_fb  = iq_fb;
      end
      default: begin
        live_ref = id_ref;
        live_fb  = id_fb;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:
        if (trig) begin
          state_next = ((div_cnt_reg == '0) && spd_mode) ? ST_SPD_ISSUE : ST_D_ISSUE;
        end
      ST_SPD_ISSUE: state_next = ST_SPD_WAIT;
      ST_SPD_WAIT:
        if (pi_done)           state_next = ST_D_ISSUE;
        else if (wait_expired) state_next = ST_IDLE;
      ST_D_ISSUE: state_next = ST_D_WAIT;
      ST_D_WAIT:
        if (pi_done)           state_next = ST_Q_ISSUE;
        else if (wait_expired) state_next = ST_IDLE;
      ST_Q_ISSUE: state_next = ST_Q_WAIT;
      ST_Q_WAIT:
        if (pi_done)           state_next = ST_COMMIT;
        else if (wait_expired) state_next = ST_IDLE;
      ST_COMMIT:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst || !en) begin
      state_reg     <= ST_IDLE;
      div_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      ref_hold_reg  <= '0;
      fb_hold_reg   <= '0;
      iq_sp_reg     <= '0;
      vd_shadow_reg <= '0;
      vq_shadow_reg <= '0;
      vd_reg        <= '0;
      vq_reg        <= '0;
      v_valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      v_valid_reg <= 1'b0;

      if (trig_accept) begin
        div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
      end

      // Snapshot operands while pi_start is high; the core sees the held copy
      // for the rest of the job. The wait counter reads k in the k-th cycle
      // after pi_start.
      if (in_issue) begin
        ref_hold_reg <= live_ref;
        fb_hold_reg  <= live_fb;
        wait_cnt_reg <= TW'(1);
      end else if (in_wait) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end

      if (job_done) begin
        case (ch)
          CH_SPD:  iq_sp_reg     <= pi_out;
          CH_Q:    vq_shadow_reg <= pi_out;
          default: vd_shadow_reg <= pi_out;
        endcase
      end

      if (state_reg == ST_COMMIT) begin
        vd_reg      <= vd_shadow_reg;
        vq_reg      <= vq_shadow_reg;
        v_valid_reg <= 1'b1;
      end
    end
  end

  // Sticky flags survive en=0; a new event in the same cycle beats clr_err.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      if (en && trig && (state_reg != ST_IDLE)) overrun_reg <= 1'b1;
      else if (clr_err)                         overrun_reg <= 1'b0;

      if (en && wait_expired) timeout_reg <= 1'b1;
      else if (clr_err)       timeout_reg <= 1'b0;
    end
  end

  pi_integ_bank #(
    .W(N + F)
  ) u_integ_bank (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (!en),
    .rd_ch   (ch),
    .rd_data (pi_integ_in),
    .wr_en   (job_done && en),
    .wr_ch   (ch),
    .wr_data (pi_integ_out)
  );

  assign pi_start    = in_issue;
  assign pi_ch       = ch;
  assign pi_ref      = in_issue ? live_ref : ref_hold_reg;
  assign pi_fb       = in_issue ? live_fb : fb_hold_reg;
  assign vd          = vd_reg;
  assign vq          = vq_reg;
  assign v_valid     = v_valid_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign overrun     = overrun_reg;
  assign timeout_err = timeout_reg;

endmodule
